// File: rtl/wb_io_arbiter.sv
// Two-master to one-slave Wishbone arbiter with round-robin grant held for the whole cycle.
// Define WB_ARB_TIMEOUT_EN to enable the bus-timeout watchdog (forced error on a hung slave).
`timescale 1ns/1ps

module wb_io_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  // master 0 (CPU IO port)
  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  input  logic [2:0]  wbm0_cti_i,
  input  logic [1:0]  wbm0_bte_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,
  // master 1 (secondary bus master)
  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  input  logic [2:0]  wbm1_cti_i,
  input  logic [1:0]  wbm1_bte_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,
  // slave side
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic [2:0]  wbs_cti_o,
  output logic [1:0]  wbs_bte_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  input  logic        wbs_rty_i,
  // one-hot {m1,m0}; doubles as the observable FSM state
  output logic [1:0]  grant_o
);

  // Handshake: cyc is the request and the grant is held until the granted master
  // drops cyc; within a grant stb is "valid" and ack/err/rty is the completion,
  // passed straight through in both directions.

  if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
    $error("wb_io_arbiter: TIMEOUT must fit in 1..2^TO_W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;

  logic        gnt;
  logic        sel_m1;
  logic        m_stb;
  logic        term;
  logic        to_hit;

  assign gnt    = (state_q != IDLE);
  assign sel_m1 = (state_q == GNT1);
  assign m_stb  = sel_m1 ? wbm1_stb_i : wbm0_stb_i;
  assign term   = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign grant_o = {state_q == GNT1, state_q == GNT0};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (wbm0_cyc_i && wbm1_cyc_i)  state_d = last_q ? GNT0 : GNT1;
        else if (wbm0_cyc_i)           state_d = GNT0;
        else if (wbm1_cyc_i)           state_d = GNT1;
      end
      GNT0: begin
        if (!wbm0_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (!wbm1_cyc_i) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (gnt && m_stb && !term) begin
      if (to_cnt_q == TO_LAST) to_hit = 1'b1;
      else                     to_cnt_d = to_cnt_q + 1'b1;
    end
    if (state_d == IDLE) to_cnt_d = '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Slave-side forwarding: zero unless a grant is held in the state register.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (gnt) begin
      wbs_adr_o = sel_m1 ? wbm1_adr_i : wbm0_adr_i;
      wbs_dat_o = sel_m1 ? wbm1_dat_i : wbm0_dat_i;
      wbs_sel_o = sel_m1 ? wbm1_sel_i : wbm0_sel_i;
      wbs_we_o  = sel_m1 ? wbm1_we_i  : wbm0_we_i;
      wbs_cyc_o = (sel_m1 ? wbm1_cyc_i : wbm0_cyc_i) & ~to_hit;
      wbs_stb_o = m_stb & ~to_hit;
      wbs_cti_o = sel_m1 ? wbm1_cti_i : wbm0_cti_i;
      wbs_bte_o = sel_m1 ? wbm1_bte_i : wbm0_bte_i;
    end
  end

  // Master-side returns: only the granted master sees slave responses.
  always_comb begin
    wbm0_dat_o = '0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_dat_o = '0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    case (state_q)
      GNT0: begin
        wbm0_dat_o = wbs_dat_i;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i | to_hit;
        wbm0_rty_o = wbs_rty_i;
      end
      GNT1: begin
        wbm1_dat_o = wbs_dat_i;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i | to_hit;
        wbm1_rty_o = wbs_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Directed self-checking bench for wb_io_arbiter: reset, tie-break, single read,
// burst hold-off, asynchronous reset mid-transfer and the timeout watchdog.
`timescale 1ns/1ps

module tb_wb_io_arbiter;

  logic        wb_clk_i;
  logic        wb_rst_n_i;
  logic [31:0] wbm0_adr_i, wbm0_dat_i, wbm1_adr_i, wbm1_dat_i;
  logic [3:0]  wbm0_sel_i, wbm1_sel_i;
  logic        wbm0_we_i, wbm0_cyc_i, wbm0_stb_i, wbm1_we_i, wbm1_cyc_i, wbm1_stb_i;
  logic [2:0]  wbm0_cti_i, wbm1_cti_i;
  logic [1:0]  wbm0_bte_i, wbm1_bte_i;
  logic [31:0] wbm0_dat_o, wbm1_dat_o;
  logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
  logic        wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [1:0]  grant_o;

  int n_cmp = 0;
  int n_bad = 0;

  wb_io_arbiter #(.TIMEOUT(4), .TO_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .wbm0_adr_i(wbm0_adr_i), .wbm0_dat_i(wbm0_dat_i), .wbm0_sel_i(wbm0_sel_i),
    .wbm0_we_i(wbm0_we_i), .wbm0_cyc_i(wbm0_cyc_i), .wbm0_stb_i(wbm0_stb_i),
    .wbm0_cti_i(wbm0_cti_i), .wbm0_bte_i(wbm0_bte_i),
    .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o),
    .wbm0_rty_o(wbm0_rty_o),
    .wbm1_adr_i(wbm1_adr_i), .wbm1_dat_i(wbm1_dat_i), .wbm1_sel_i(wbm1_sel_i),
    .wbm1_we_i(wbm1_we_i), .wbm1_cyc_i(wbm1_cyc_i), .wbm1_stb_i(wbm1_stb_i),
    .wbm1_cti_i(wbm1_cti_i), .wbm1_bte_i(wbm1_bte_i),
    .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o),
    .wbm1_rty_o(wbm1_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o)
  );

  // Clock and global time limit.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk2({tag, "_grant"}, grant_o, 2'b00);
    chk({tag, "_wbs_adr"}, wbs_adr_o, 32'h0);
    chk({tag, "_wbs_dat"}, wbs_dat_o, 32'h0);
    chk({tag, "_wbs_sel"}, 32'(wbs_sel_o), 32'h0);
    chk({tag, "_wbs_cti"}, 32'(wbs_cti_o), 32'h0);
    chk({tag, "_wbs_bte"}, 32'(wbs_bte_o), 32'h0);
    chkb({tag, "_wbs_we"}, wbs_we_o, 1'b0);
    chkb({tag, "_wbs_cyc"}, wbs_cyc_o, 1'b0);
    chkb({tag, "_wbs_stb"}, wbs_stb_o, 1'b0);
    chk({tag, "_m0_dat"}, wbm0_dat_o, 32'h0);
    chk({tag, "_m1_dat"}, wbm1_dat_o, 32'h0);
    chkb({tag, "_m0_ack"}, wbm0_ack_o, 1'b0);
    chkb({tag, "_m1_ack"}, wbm1_ack_o, 1'b0);
    chkb({tag, "_m0_err"}, wbm0_err_o, 1'b0);
    chkb({tag, "_m1_err"}, wbm1_err_o, 1'b0);
    chkb({tag, "_m0_rty"}, wbm0_rty_o, 1'b0);
    chkb({tag, "_m1_rty"}, wbm1_rty_o, 1'b0);
  endtask

  // Inputs change at posedge+2; checks follow at posedge+3.
  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  initial begin
    logic seen_err;
    logic stb_drop;
    wb_rst_n_i = 1'b0;
    wbm0_adr_i = 32'h1100; wbm0_dat_i = 32'h0A0A_0A0A; wbm0_sel_i = 4'hF; wbm0_we_i = 1'b1;
    wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm0_cti_i = 3'b010; wbm0_bte_i = 2'b01;
    wbm1_adr_i = 32'h2200; wbm1_dat_i = 32'h0B0B_0B0B; wbm1_sel_i = 4'hF; wbm1_we_i = 1'b0;
    wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0; wbm1_cti_i = 3'b000; wbm1_bte_i = 2'b00;
    wbs_dat_i = 32'hDEAD_BEEF; wbs_ack_i = 1'b1; wbs_err_i = 1'b1; wbs_rty_i = 1'b1;

    // Reset: everything zero even with a requesting master and an active slave.
    #3;
    chk_all_zero("reset");
    wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_we_i = 1'b0;
    wbm0_cti_i = 3'b000; wbm0_bte_i = 2'b00;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    #9 wb_rst_n_i = 1'b1;
    tick();
    #1 chk2("idle_after_reset", grant_o, 2'b00);

    // Tie after reset: m0 first, one IDLE gap, then m1.
    wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1;
    wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    #1 chkb("tie_latency_cyc", wbs_cyc_o, 1'b0);
    tick();
    #1 chk2("tie_grant_m0", grant_o, 2'b01);
    chk("tie_adr_m0", wbs_adr_o, 32'h1100);
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h0000_1111;
    #1 chkb("tie_m0_ack", wbm0_ack_o, 1'b1);
    chkb("tie_m1_no_ack", wbm1_ack_o, 1'b0);
    chk("tie_m0_dat", wbm0_dat_o, 32'h0000_1111);
    chk("tie_m1_dat_zero", wbm1_dat_o, 32'h0);
    tick();
    wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
    #1 chk2("m0_drop_grant_held", grant_o, 2'b01);
    chkb("m0_drop_wbs_cyc", wbs_cyc_o, 1'b0);
    tick();
    #1 chk2("idle_gap", grant_o, 2'b00);
    tick();
    #1 chk2("tie_grant_m1", grant_o, 2'b10);
    chk("tie_adr_m1", wbs_adr_o, 32'h2200);
    wbs_rty_i = 1'b1;
    #1 chkb("m1_rty", wbm1_rty_o, 1'b1);
    chkb("m0_no_rty", wbm0_rty_o, 1'b0);
    wbs_rty_i = 1'b0; wbs_ack_i = 1'b1;
    #1 chkb("m1_ack", wbm1_ack_o, 1'b1);
    chkb("m0_no_ack", wbm0_ack_o, 1'b0);
    tick();
    wbs_ack_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
    tick();
    #1 chk2("m1_done_idle", grant_o, 2'b00);
    wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    tick();
    #1 chk2("tie2_grant_m0", grant_o, 2'b01);
    wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
    tick();
    #1 chk2("tie2_idle", grant_o, 2'b00);

    // Slave terminations while idle are ignored.
    wbs_ack_i = 1'b1; wbs_err_i = 1'b1;
    #1 chkb("idle_term_m0_ack", wbm0_ack_o, 1'b0);
    chkb("idle_term_m1_err", wbm1_err_o, 1'b0);
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0;

    // Single m0 read at 0x1100, slave acks two cycles after strobe.
    wbm0_adr_i = 32'h1100; wbm0_we_i = 1'b0; wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1;
    #1 chkb("rd_latency_cyc", wbs_cyc_o, 1'b0);
    tick();
    #1 chkb("rd_wbs_cyc", wbs_cyc_o, 1'b1);
    chkb("rd_wbs_stb", wbs_stb_o, 1'b1);
    chk2("rd_grant", grant_o, 2'b01);
    chk("rd_adr", wbs_adr_o, 32'h1100);
    chkb("rd_we", wbs_we_o, 1'b0);
    chkb("rd_no_ack1", wbm0_ack_o, 1'b0);
    tick();
    #1 chkb("rd_no_ack2", wbm0_ack_o, 1'b0);
    tick();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hDEAD_BEEF;
    #1 chkb("rd_ack", wbm0_ack_o, 1'b1);
    chk("rd_dat", wbm0_dat_o, 32'hDEAD_BEEF);
    tick();
    wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0;
    #1 chkb("rd_ack_single", wbm0_ack_o, 1'b0);
    tick();
    #1 chk2("rd_grant_release", grant_o, 2'b00);

    // 4-beat incrementing burst on m0 while m1 waits.
    wbm0_adr_i = 32'h3000; wbm0_cti_i = 3'b010; wbm0_cyc_i = 1'b1; wbm0_stb_i = 1'b1;
    tick();
    #1 chk2("burst_grant", grant_o, 2'b01);
    wbm1_adr_i = 32'h4000; wbm1_we_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wbm0_adr_i = 32'h3000 + 32'(4 * b);
      wbm0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      wbs_ack_i = 1'b1;
      #1 chkb($sformatf("burst%0d_m0_ack", b), wbm0_ack_o, 1'b1);
      chkb($sformatf("burst%0d_m1_ack", b), wbm1_ack_o, 1'b0);
      chk($sformatf("burst%0d_adr", b), wbs_adr_o, 32'h3000 + 32'(4 * b));
      chk($sformatf("burst%0d_cti", b), 32'(wbs_cti_o), (b == 3) ? 32'd7 : 32'd2);
      tick();
    end
    wbs_ack_i = 1'b0; wbm0_cyc_i = 1'b0; wbm0_stb_i = 1'b0; wbm0_cti_i = 3'b000;
    #1 chk2("burst_end_held", grant_o, 2'b01);
    chkb("burst_end_m1_no_ack", wbm1_ack_o, 1'b0);
    tick();
    #1 chk2("burst_gap", grant_o, 2'b00);
    tick();
    #1 chk2("m1_after_burst", grant_o, 2'b10);
    chk("m1_after_burst_adr", wbs_adr_o, 32'h4000);

    // Asynchronous reset in GNT1 mid-transfer, then m1 re-requests.
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_F00D;
    #1 chkb("pre_rst_m1_ack", wbm1_ack_o, 1'b1);
    #1 wb_rst_n_i = 1'b0;
    #1 chk_all_zero("async_rst");
    wbs_ack_i = 1'b0;
    #1 wb_rst_n_i = 1'b1;
    tick();
    #1 chk2("post_rst_grant_m1", grant_o, 2'b10);
    chkb("post_rst_wbs_cyc", wbs_cyc_o, 1'b1);
    wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
    tick();
    tick();
    #1 chk2("post_rst_idle", grant_o, 2'b00);

    // Hung slave on an m1 write.
    wbm1_adr_i = 32'h5000; wbm1_we_i = 1'b1; wbm1_cyc_i = 1'b1; wbm1_stb_i = 1'b1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 1; c <= 5; c++) begin
      #1 chkb($sformatf("to_cyc%0d_err", c), wbm1_err_o, c == 4);
      chkb($sformatf("to_cyc%0d_stb", c), wbs_stb_o, c != 4);
      chkb($sformatf("to_cyc%0d_cyc", c), wbs_cyc_o, c != 4);
      chk2($sformatf("to_cyc%0d_grant", c), grant_o, 2'b10);
      tick();
    end
`else
    seen_err = 1'b0;
    stb_drop = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      seen_err = seen_err | wbm1_err_o;
      stb_drop = stb_drop | ~wbs_stb_o;
      tick();
    end
    chkb("hung_no_err", seen_err, 1'b0);
    chkb("hung_stb_held", stb_drop, 1'b0);
    chk2("hung_grant_held", grant_o, 2'b10);
`endif
    wbm1_cyc_i = 1'b0; wbm1_stb_i = 1'b0;
    tick();
    #1 chk2("hung_release", grant_o, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_io_arbiter.md
Name: wb_io_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter placed in front of the IO interconnect's master port.
- Master 0 is the CPU IO port; master 1 is a secondary bus master, e.g. a video/bot DMA engine.
- Fair round-robin grant, held for the whole cycle, with an optional bus-timeout watchdog.
- Slave side connects directly to the interconnect's wb_io_* inputs.

Parameters:
TIMEOUT, 255, cycles a granted strobe may wait for ack/err/rty before a forced error (1..2^TO_W-1)
TO_W, 8, width of the timeout counter

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
wbm0_adr_i, wbm1_adr_i  in  32  master address
wbm0_dat_i, wbm1_dat_i  in  32  master write data
wbm0_sel_i, wbm1_sel_i  in  4  byte selects
wbm0_we_i, wbm1_we_i  in  1  write enable
wbm0_cyc_i, wbm1_cyc_i  in  1  cycle valid; acts as the request
wbm0_stb_i, wbm1_stb_i  in  1  strobe
wbm0_cti_i, wbm1_cti_i  in  3  cycle type
wbm0_bte_i, wbm1_bte_i  in  2  burst type
wbm0_dat_o, wbm1_dat_o  out  32  read data
wbm0_ack_o, wbm1_ack_o  out  1  acknowledge
wbm0_err_o, wbm1_err_o  out  1  error
wbm0_rty_o, wbm1_rty_o  out  1  retry
wbs_adr_o / wbs_dat_o / wbs_sel_o  out  32/32/4  forwarded address, data, selects
wbs_we_o / wbs_cyc_o / wbs_stb_o  out  1 each  forwarded controls
wbs_cti_o / wbs_bte_o  out  3/2  forwarded burst info
wbs_dat_i  in  32  slave read data
wbs_ack_i / wbs_err_i / wbs_rty_i  in  1 each  slave termination
grant_o  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Reset: wb_rst_n_i low asynchronously forces state IDLE, last-grant = 1, timeout counter = 0.
  - All wbs_* outputs 0; all wbm*_ack/err/rty/dat_o 0; grant_o 00.
- States: IDLE, GNT0, GNT1.
  - The state register is the only source of grant.
  - All wbs_* and grant_o outputs are decoded from registered state.
- IDLE, transitions at the next clock edge:
  - only cyc0 high -> GNT0;
  - only cyc1 high -> GNT1;
  - both high -> the master not equal to last-grant;
  - neither -> stay IDLE.
  - Grant latency: one cycle from cyc assertion to wbs_cyc_o.
- GNTn:
  - wbs_* outputs = master n's inputs, combinational pass-through.
  - wbmn_dat_o/ack/err/rty = slave inputs.
  - The other master sees ack/err/rty = 0 and dat_o = 0.
  - On the edge where cycn is sampled low: go to IDLE and set last-grant = n.
  - At least one IDLE cycle always separates two grants, including back-to-back requests from the same master.
- Grant is never pre-empted:
  - Burst cycles (cti != 000) and read-modify-write sequences hold cyc and therefore keep the grant.
  - The requesting master stalls until then.
- A master dropping cyc while not granted is legal and has no effect.
- Slave terminations outside a grant (IDLE) are ignored.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined: in GNTn, the counter increments each cycle stb is high and ack/err/rty are all low.
  - It clears on any termination, on stb low, or on leaving the grant.
  - When the counter equals TIMEOUT-1 with no termination:
    - that cycle drives wbmn_err_o = 1 and forces wbs_cyc_o/wbs_stb_o = 0;
    - the counter is then cleared;
    - the grant persists until master n drops cyc.
- Not defined: no counter exists, no forced error is generated, and a hung slave holds the grant indefinitely.

Test Plan:
- Single m0 read at 0x1100, slave acks 2 cycles after wbs_stb_o -> wbs_cyc_o rises 1 cycle after wbm0_cyc_i; wbm0_ack_o pulses once with data 0xDEADBEEF; grant_o 01 -> 00.
- Both masters raise cyc in the same cycle after reset -> m0 granted first; m1 granted after m0 drops cyc plus 1 IDLE cycle; next tie goes to m0.
- m0 runs a 4-beat incrementing burst (cti 010 then 111) while m1 requests -> m1 sees no ack and no wbs activity until m0 finishes all 4 acks.
- Reset asserted in GNT1 mid-transfer -> all outputs 0 immediately, with no clock needed; after release, m1 re-requests and is granted.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=4, slave never acks a m1 write -> wbm1_err_o=1 on the 4th stb cycle with wbs_stb_o=0; without the macro, no err after 1000 cycles.
